// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Op encodings, FSM state encoding, divider iteration count, magnitude helper.
package md_pkg;

    localparam logic [1:0] MD_OP_MULT  = 2'b00;
    localparam logic [1:0] MD_OP_MULTU = 2'b01;
    localparam logic [1:0] MD_OP_DIV   = 2'b10;
    localparam logic [1:0] MD_OP_DIVU  = 2'b11;

    localparam int MD_DIV_ITER = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    // Two's complement magnitude when sgn is set, raw value otherwise.
    function automatic logic [31:0] md_abs(input logic [31:0] v,
                                           input logic        sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_core.sv
// Iterative 32-step restoring divider on unsigned magnitudes.
// Ports: clk, resetn (async low), load (latch operands, clear counter),
//   step (run one iteration), dividend/divisor (magnitudes, sampled on load),
//   done (high during the final step), quo/rem (post-step values, valid with done).
module div_core
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    logic [31:0] rem_q, quo_q, dsr_q;
    logic [4:0]  cnt_q;
    logic [32:0] part, diff;
    logic        sub_ok;
    logic [31:0] rem_d, quo_d;

    // quo_q starts as the dividend; its MSB is shifted into the
    // partial remainder while quotient bits enter from the LSB.
    always_comb begin
        part   = {rem_q, quo_q[31]};
        diff   = part - {1'b0, dsr_q};
        sub_ok = ~diff[32];
        rem_d  = sub_ok ? diff[31:0] : part[31:0];
        quo_d  = {quo_q[30:0], sub_ok};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 5'd1;
        end
    end

    assign done = step && (cnt_q == 5'(MD_DIV_ITER - 1));
    assign quo  = quo_d;
    assign rem  = rem_d;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, operand latches, multiplier, sign fix.
// Ports: clk, resetn, md_start/md_op/md_src1/md_src2 request, md_cancel flush,
//   md_ready/md_busy, mul_out_valid/div_out_valid pulses, md_result {HI,LO}.
// Build option: MD_DIVZERO_FAST_EN finishes a zero-divisor divide in one step.
module muldiv_ctrl
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic [31:0] md_src1,
    input  logic [31:0] md_src2,
    input  logic        md_cancel,
    output logic        md_ready,
    output logic        md_busy,
    output logic        mul_out_valid,
    output logic        div_out_valid,
    output logic [63:0] md_result
);

    md_state_e   state_q;
    logic [1:0]  op_q;
    logic [31:0] src1_q, src2_q;

    logic        accept, in_sdiv, sdiv, smul;
    logic        dv_done, dv_step, dz_fast, div_fin;
    logic [31:0] dv_quo, dv_rem, a_mag, qm, rm, qf, rf;
    logic [63:0] a_ext, b_ext, prod;

    assign accept  = md_start && md_ready && !md_cancel;
    assign in_sdiv = (md_op == MD_OP_DIV);
    assign dv_step = (state_q == MD_DIV) && !md_cancel;

    div_core u_div (
        .clk      (clk),
        .resetn   (resetn),
        .load     (accept && md_op[1]),
        .step     (dv_step),
        .dividend (md_abs(md_src1, in_sdiv)),
        .divisor  (md_abs(md_src2, in_sdiv)),
        .done     (dv_done),
        .quo      (dv_quo),
        .rem      (dv_rem)
    );

    // Sign-extend for MULT; the low 64 bits of the product are exact.
    assign smul  = (op_q == MD_OP_MULT);
    assign a_ext = {{32{smul & src1_q[31]}}, src1_q};
    assign b_ext = {{32{smul & src2_q[31]}}, src2_q};
    assign prod  = a_ext * b_ext;

    assign sdiv  = (op_q == MD_OP_DIV);
    assign a_mag = md_abs(src1_q, sdiv);

`ifdef MD_DIVZERO_FAST_EN
    assign dz_fast = (src2_q == 32'd0);
`else
    assign dz_fast = 1'b0;
`endif

    // A zero divisor makes every trial subtract succeed, so the
    // shortcut reproduces the iterative result exactly.
    assign div_fin = dv_done || dz_fast;
    assign qm = dz_fast ? 32'hFFFF_FFFF : dv_quo;
    assign rm = dz_fast ? a_mag : dv_rem;
    assign qf = (sdiv && (src1_q[31] ^ src2_q[31])) ? (~qm + 32'd1) : qm;
    assign rf = (sdiv && src1_q[31]) ? (~rm + 32'd1) : rm;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= MD_IDLE;
            op_q      <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            md_result <= '0;
        end else if (md_cancel) begin
            state_q <= MD_IDLE;
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (md_start) begin
                        op_q    <= md_op;
                        src1_q  <= md_src1;
                        src2_q  <= md_src2;
                        state_q <= md_op[1] ? MD_DIV : MD_MUL;
                    end
                end
                MD_MUL: begin
                    md_result <= prod;
                    state_q   <= MD_DONE;
                end
                MD_DIV: begin
                    if (div_fin) begin
                        md_result <= {rf, qf};
                        state_q   <= MD_DONE;
                    end
                end
                MD_DONE: state_q <= MD_IDLE;
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign md_ready      = (state_q == MD_IDLE);
    assign md_busy       = ~md_ready;
    // Cancel masks the pulse in the same cycle it is sampled.
    assign mul_out_valid = (state_q == MD_DONE) && !op_q[1] && !md_cancel;
    assign div_out_valid = (state_q == MD_DONE) &&  op_q[1] && !md_cancel;

endmodule
